ser_arbiter: RTL and testbench

SER_ARBITER -- requirements
Module: ser_arbiter

---
 rtl/ser_arbiter.sv | 121 ++++++++++++
 tb/tb_ser_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ser_arbiter.sv
// Round-robin arbiter that feeds several requesters into one shared serializer.
// Optional SER_ARBITER_DROP_CNT_EN adds drop_cnt_o, a saturating count of discarded malformed requests.
module ser_arbiter #(
    parameter int REQ_NUM = 4,
    parameter int DATA_W  = 16,
    parameter int MOD_W   = $clog2(DATA_W)
) (
    input  logic                        clk_i,
    input  logic                        srst_i,
    input  logic [REQ_NUM*DATA_W-1:0]   req_data_i,
    input  logic [REQ_NUM*MOD_W-1:0]    req_mod_i,
    input  logic [REQ_NUM-1:0]          req_val_i,
    output logic [REQ_NUM-1:0]          req_ready_o,
    output logic [DATA_W-1:0]           ser_data_o,
    output logic [MOD_W-1:0]            ser_data_mod_o,
    output logic                        ser_data_val_o,
    input  logic                        ser_busy_i,
    output logic [$clog2(REQ_NUM)-1:0]  grant_id_o,
    output logic                        err_o
`ifdef SER_ARBITER_DROP_CNT_EN
    ,
    output logic [7:0]                  drop_cnt_o
`endif
);
    localparam int ID_W = $clog2(REQ_NUM);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_END} state_t;

    state_t          r_state;
    logic [ID_W-1:0] r_ptr;
    logic [1:0]      r_to_cnt;

    logic [ID_W-1:0] w_win;
    logic [ID_W-1:0] w_idx;
    logic            w_any;
    logic [MOD_W-1:0] w_mod;
    logic            w_bad;
    logic            w_acc;

    // Rotating priority search; REQ_NUM is a power of two so the index wraps by truncation.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        w_idx = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            w_idx = r_ptr + ID_W'(i);
            if (!w_any && req_val_i[w_idx]) begin
                w_win = w_idx;
                w_any = 1'b1;
            end
        end
    end

    assign w_mod = req_mod_i[w_win*MOD_W +: MOD_W];
    // Bit counts 1 and 2 cannot be serialized; such words are accepted and thrown away.
    assign w_bad = (w_mod == MOD_W'(1)) || (w_mod == MOD_W'(2));
    assign w_acc = (r_state == IDLE) && !ser_busy_i && w_any && !srst_i;
    assign req_ready_o = w_acc ? (REQ_NUM'(1) << w_win) : '0;

`ifdef SER_ARBITER_DROP_CNT_EN
    logic [7:0] r_drop;
    assign drop_cnt_o = r_drop;
`endif

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            r_state        <= IDLE;
            r_ptr          <= '0;
            r_to_cnt       <= '0;
            ser_data_o     <= '0;
            ser_data_mod_o <= '0;
            ser_data_val_o <= 1'b0;
            grant_id_o     <= '0;
            err_o          <= 1'b0;
`ifdef SER_ARBITER_DROP_CNT_EN
            r_drop         <= '0;
`endif
        end else begin
            ser_data_val_o <= 1'b0;
            err_o          <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        r_ptr <= w_win + ID_W'(1);
                        if (w_bad) begin
`ifdef SER_ARBITER_DROP_CNT_EN
                            if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
`endif
                        end else begin
                            ser_data_o     <= req_data_i[w_win*DATA_W +: DATA_W];
                            ser_data_mod_o <= w_mod;
                            grant_id_o     <= w_win;
                            ser_data_val_o <= 1'b1;
                            r_state        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    r_to_cnt <= '0;
                    r_state  <= WAIT_START;
                end
                WAIT_START: begin
                    // Serializer gets three cycles to raise busy before we give up.
                    if (ser_busy_i) begin
                        r_state <= WAIT_END;
                    end else if (r_to_cnt == 2'd2) begin
                        err_o   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 2'd1;
                    end
                end
                WAIT_END: begin
                    if (!ser_busy_i) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ser_arbiter.sv
// Randomized bench for ser_arbiter: a transaction-timing reference model checks every cycle.
module tb_ser_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MW = 4;

    logic            clk = 1'b0;
    logic            srst_i = 1'b1;
    logic [N*DW-1:0] req_data = '0;
    logic [N*MW-1:0] req_mod = '0;
    logic [N-1:0]    req_val = '0;
    logic [N-1:0]    ready;
    logic [DW-1:0]   sdata;
    logic [MW-1:0]   smod;
    logic            sval;
    logic            busy = 1'b0;
    logic [1:0]      gid;
    logic            err;
`ifdef SER_ARBITER_DROP_CNT_EN
    logic [7:0]      drop_cnt;
`endif

    always #5 clk = ~clk;

    ser_arbiter #(.REQ_NUM(N), .DATA_W(DW), .MOD_W(MW)) dut (
        .clk_i(clk), .srst_i(srst_i),
        .req_data_i(req_data), .req_mod_i(req_mod), .req_val_i(req_val),
        .req_ready_o(ready),
        .ser_data_o(sdata), .ser_data_mod_o(smod), .ser_data_val_o(sval),
        .ser_busy_i(busy), .grant_id_o(gid), .err_o(err)
`ifdef SER_ARBITER_DROP_CNT_EN
        , .drop_cnt_o(drop_cnt)
`endif
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: transfer timestamps rather than a state machine
    int   cyc = 0;
    int   m_ptr = 0, t_acc = 0, err_due = -1, m_drops = 0, n_errp = 0;
    bit   m_xfer = 0, m_wend = 0;
    logic [DW-1:0] e_data;
    logic [MW-1:0] e_mod;
    int   e_gid;
    int   grants[$];
    int   drops[$];
    logic [DW-1:0] iss_data[$];
    logic [MW-1:0] iss_mod[$];

    bit gen_en = 0, noise_en = 0, never_busy = 0;
    int busy_len_fix = 0, sdelay = -1, busy_left = 0;
    bit acc[N];

    function automatic int rr(input int p, input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor + model, sampling on the falling edge
    initial begin : mon
        int w;
        logic [N-1:0] er;
        logic [MW-1:0] m;
        bit ev;
        forever begin
            @(negedge clk);
            if (srst_i) begin
                chk("rst_ready", ready, 0);
                chk("rst_val", sval, 0);
                chk("rst_data", sdata, 0);
                chk("rst_mod", smod, 0);
                chk("rst_gid", gid, 0);
                chk("rst_err", err, 0);
`ifdef SER_ARBITER_DROP_CNT_EN
                chk("rst_drop", drop_cnt, 0);
`endif
                m_ptr = 0; m_xfer = 0; m_wend = 0; err_due = -1; m_drops = 0;
            end else begin
                er = '0;
                w = -1;
                if (!m_xfer && !busy && req_val != 0) begin
                    w = rr(m_ptr, req_val);
                    er[w] = 1'b1;
                end
                chk("ready", ready, er);
                ev = m_xfer && (cyc == t_acc + 1);
                chk("valid", sval, ev);
                chk("err", err, cyc == err_due);
                if (err) n_errp++;
`ifdef SER_ARBITER_DROP_CNT_EN
                chk("drop_cnt", drop_cnt, m_drops);
`endif
                if (sval) begin
                    if (!noise_en) chk("val_busy", busy, 0);
                    if (ev) begin
                        chk("data", sdata, e_data);
                        chk("mod", smod, e_mod);
                        chk("gid", gid, e_gid);
                    end
                    iss_data.push_back(sdata);
                    iss_mod.push_back(smod);
                    if (!never_busy) sdelay = $urandom_range(0, 2);
                end
                // Transfer progress: start window is the 3 cycles after the issue cycle
                if (m_xfer && cyc >= t_acc + 2) begin
                    if (!m_wend) begin
                        if (busy) m_wend = 1;
                        else if (cyc == t_acc + 4) begin m_xfer = 0; err_due = cyc + 1; end
                    end else if (!busy) begin
                        m_xfer = 0; m_wend = 0;
                    end
                end
                if (w >= 0) begin
                    m = req_mod[w*MW +: MW];
                    if (m == 1 || m == 2) begin
                        drops.push_back(w);
                        if (m_drops < 255) m_drops++;
                    end else begin
                        m_xfer = 1; t_acc = cyc;
                        e_data = req_data[w*DW +: DW]; e_mod = m; e_gid = w;
                        grants.push_back(w);
                    end
                    m_ptr = (w + 1) % N;
                end
                for (int k = 0; k < N; k++)
                    if (ready[k] && req_val[k]) acc[k] = 1;
            end
        end
    end

    // Serializer model and random requesters, driven just after the rising edge
    initial forever begin
        @(posedge clk);
        #1;
        if (srst_i) begin busy_left = 0; sdelay = -1; end
        if (sdelay == 0) begin
            busy_left = (busy_len_fix != 0) ? busy_len_fix : $urandom_range(1, 6);
            sdelay = -1;
        end else if (sdelay > 0) sdelay--;
        busy = (busy_left > 0) || (noise_en && $urandom_range(0, 9) == 0);
        if (busy_left > 0) busy_left--;
        for (int k = 0; k < N; k++) begin
            if (acc[k]) begin req_val[k] = 1'b0; acc[k] = 0; end
            if (gen_en && !req_val[k] && $urandom_range(0, 3) == 0) begin
                req_val[k] = 1'b1;
                req_data[k*DW +: DW] = DW'($urandom);
                req_mod[k*MW +: MW] = ($urandom_range(0, 5) == 0) ? MW'($urandom_range(1, 2))
                                                                   : MW'($urandom_range(0, 15));
            end
        end
    end

    task automatic set_req(input int k, input logic [DW-1:0] d, input logic [MW-1:0] m);
        req_data[k*DW +: DW] = d;
        req_mod[k*MW +: MW] = m;
        req_val[k] = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_grants(input int n, input int budget);
        for (int i = 0; i < budget && grants.size() < n; i++) step();
        chk("wait_grants", grants.size() >= n, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && (m_xfer || req_val != 0); i++) step();
        chk("wait_idle", (m_xfer || req_val != 0), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        srst_i = 1'b1;
        #1;
        chk("async_val", sval, 0);
        chk("async_gid", gid, 0);
        chk("async_ready", ready, 0);
        chk("async_data", sdata, 0);
        grants.delete(); drops.delete(); iss_data.delete(); iss_mod.delete();
        n_errp = 0;
        repeat (2) @(posedge clk);
        #2;
        srst_i = 1'b0;
    endtask

    initial begin : wdog
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        srst_i = 1'b0;

        // Single request on requester 0
        set_req(0, 16'hF0F0, 4'd0);
        wait_grants(1, 20);
        wait_idle(50);
        chk("t1_gid", grants[0], 0);
        chk("t1_data", iss_data[0], 16'hF0F0);

        // All four at once against a 16-cycle busy serializer
        do_reset();
        busy_len_fix = 16;
        set_req(0, 16'h1111, 4'd0); set_req(1, 16'h2222, 4'd3);
        set_req(2, 16'h3333, 4'd8); set_req(3, 16'h4444, 4'd15);
        wait_grants(4, 300);
        wait_idle(100);
        for (int i = 0; i < 4; i++) chk("t2_order", grants[i], i);
        chk("t2_mod3", iss_mod[3], 15);
        busy_len_fix = 0;

        // Malformed request on 2 dropped, request 3 with 5 bits issued
        do_reset();
        set_req(2, 16'hDEAD, 4'd1); set_req(3, 16'hBEEF, 4'd5);
        wait_idle(100);
        chk("t3_ndrop", drops.size(), 1);
        chk("t3_drop_id", drops[0], 2);
        chk("t3_ngrant", grants.size(), 1);
        chk("t3_grant", grants[0], 3);
        chk("t3_mod", iss_mod[0], 5);
        chk("t3_data", iss_data[0], 16'hBEEF);

        // Serializer never starts: timeout error, then next request still served
        do_reset();
        never_busy = 1;
        set_req(0, 16'hA5A5, 4'd0);
        wait_idle(50);
        step(); step();
        chk("t4_errp", n_errp, 1);
        set_req(1, 16'h5A5A, 4'd7);
        wait_idle(50);
        step(); step();
        chk("t4_grant1", grants[1], 1);
        chk("t4_errp2", n_errp, 2);
        never_busy = 0;

        // Reset during WAIT_END: pointer back to 0, held requests survive
        do_reset();
        busy_len_fix = 12;
        set_req(2, 16'h0C0C, 4'd0);
        for (int i = 0; i < 50 && !m_wend; i++) step();
        chk("t5_wend", m_wend, 1);
        set_req(1, 16'h1010, 4'd0);
        set_req(3, 16'h3030, 4'd0);
        do_reset();
        busy_len_fix = 0;
        wait_grants(1, 20);
        chk("t5_first", grants[0], 1);
        wait_idle(100);
        chk("t5_second", grants[1], 3);

        // Random traffic with external busy noise and malformed words
        do_reset();
        gen_en = 1; noise_en = 1;
        repeat (3000) step();
        gen_en = 0;
        wait_idle(500);
        noise_en = 0;
        chk("rand_activity", grants.size() > 20, 1);
        chk("rand_drops", drops.size() > 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
